// File: rtl/hopfield_pkg.sv
// Shared types and helpers for the sequential-update Hopfield core.
package hopfield_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LEARN,
    S_RECALL,
    S_DONE
  } state_t;

  // Width of a neuron index; a single bit is kept even for tiny arrays.
  function automatic int idx_bits(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Activation accumulator width: one weight plus log2(N) growth plus a guard bit.
  function automatic int acc_bits(input int n, input int w);
    return w + $clog2(n) + 1;
  endfunction

  // Add and clamp symmetrically to [-lim, +lim].
  function automatic int sat_add(input int a, input int b, input int lim);
    int s;
    s = a + b;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

endpackage

// File: rtl/hopfield_row_mac.sv
// Combinational signed dot product of one weight row with bipolar states,
// skipping the self-connection of neuron k.
module hopfield_row_mac
  import hopfield_pkg::*;
#(
  parameter int N = 16,
  parameter int W_BITS = 4,
  localparam int IDX_BITS = idx_bits(N),
  localparam int ACC_BITS = acc_bits(N, W_BITS)
) (
  input  logic [N*W_BITS-1:0]        row,
  input  logic [N-1:0]               state,
  input  logic [IDX_BITS-1:0]        k,
  output logic signed [ACC_BITS-1:0] act
);

  logic signed [ACC_BITS-1:0] acc;
  logic signed [ACC_BITS-1:0] wext;

  // Accumulate +w or -w per neighbour depending on its bipolar state.
  always_comb begin
    acc  = '0;
    wext = '0;
    for (int j = 0; j < N; j++) begin
      wext = {{(ACC_BITS-W_BITS){row[j*W_BITS+W_BITS-1]}}, row[j*W_BITS +: W_BITS]};
      if (IDX_BITS'(j) != k) begin
        acc = state[j] ? (acc + wext) : (acc - wext);
      end
    end
  end

  assign act = acc;

endmodule

// File: rtl/hopfield_seq_core.sv
// Hopfield associative memory: row-per-cycle Hebbian learning and
// neuron-per-cycle asynchronous recall with convergence/timeout detection.
module hopfield_seq_core
  import hopfield_pkg::*;
#(
  parameter int N = 16,
  parameter int W_BITS = 4,
  parameter int MAX_SWEEPS = 8,
  parameter int THRESH = 0,
  localparam int IDX_BITS = idx_bits(N),
  localparam int ACC_BITS = acc_bits(N, W_BITS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               pattern_in,
  input  logic                       learn_valid,
  output logic                       learn_ready,
  input  logic                       recall_valid,
  output logic                       recall_ready,
  input  logic                       clear_weights,
  output logic [N-1:0]               state_out,
  output logic                       done,
  output logic                       converged,
  output logic                       timeout,
  output logic                       busy,
  input  logic [IDX_BITS-1:0]        rd_row,
  input  logic [IDX_BITS-1:0]        rd_col,
  output logic signed [W_BITS-1:0]   rd_data
);

  localparam int WMAX = (1 << (W_BITS - 1)) - 1;
  localparam int SW_BITS = (MAX_SWEEPS < 2) ? 1 : $clog2(MAX_SWEEPS + 1);
  localparam logic signed [ACC_BITS-1:0] THR = ACC_BITS'(THRESH);

  state_t                     state, state_nxt;
  logic signed [W_BITS-1:0]   w [N][N];
  logic [N-1:0]               pat_r, s;
  logic [IDX_BITS-1:0]        row, k;
  logic [SW_BITS-1:0]         sweep;
  logic                       flip, conv_r, tmo_r;
  logic [N*W_BITS-1:0]        row_vec;
  logic signed [ACC_BITS-1:0] act;
  logic                       s_new, changed, last_k, sweep_last;
  logic                       clr_acc, learn_acc, recall_acc;

  // Present the weight row of the neuron currently being updated.
  always_comb begin
    row_vec = '0;
    for (int j = 0; j < N; j++) begin
      row_vec[j*W_BITS +: W_BITS] = w[k][j];
    end
  end

  hopfield_row_mac #(.N(N), .W_BITS(W_BITS)) u_mac (
    .row   (row_vec),
    .state (s),
    .k     (k),
    .act   (act)
  );

  // Threshold decision, request arbitration (clear > learn > recall) and sweep bookkeeping.
  always_comb begin
    s_new = s[k];
    if (act > THR) s_new = 1'b1;
    else if (act < THR) s_new = 1'b0;
    changed    = (s_new != s[k]);
    last_k     = (k == IDX_BITS'(N - 1));
    sweep_last = ((int'(sweep) + 1) == MAX_SWEEPS);
    clr_acc    = (state == S_IDLE) && clear_weights;
    learn_acc  = (state == S_IDLE) && !clear_weights && learn_valid;
    recall_acc = (state == S_IDLE) && !clear_weights && !learn_valid && recall_valid;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and handshake/status outputs.
  always_comb begin
    state_nxt    = state;
    learn_ready  = 1'b0;
    recall_ready = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        learn_ready  = 1'b1;
        recall_ready = 1'b1;
        busy         = 1'b0;
        if (learn_acc) state_nxt = S_LEARN;
        else if (recall_acc) state_nxt = S_RECALL;
      end
      S_LEARN: begin
        if (row == IDX_BITS'(N - 1)) state_nxt = S_IDLE;
      end
      S_RECALL: begin
        if (last_k && (!(flip || changed) || sweep_last)) state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Learn row counter, recall neuron/sweep counters, neuron states and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r  <= '0;
      s      <= '0;
      row    <= '0;
      k      <= '0;
      sweep  <= '0;
      flip   <= 1'b0;
      conv_r <= 1'b0;
      tmo_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (learn_acc) begin
            pat_r <= pattern_in;
            row   <= '0;
          end else if (recall_acc) begin
            s      <= pattern_in;
            conv_r <= 1'b0;
            tmo_r  <= 1'b0;
            k      <= '0;
            sweep  <= '0;
            flip   <= 1'b0;
          end
        end
        S_LEARN: row <= row + IDX_BITS'(1);
        S_RECALL: begin
          s[k] <= s_new;
          if (last_k) begin
            if (!(flip || changed)) begin
              conv_r <= 1'b1;
            end else if (sweep_last) begin
              tmo_r <= 1'b1;
            end else begin
              sweep <= sweep + SW_BITS'(1);
              k     <= '0;
              flip  <= 1'b0;
            end
          end else begin
            k    <= k + IDX_BITS'(1);
            flip <= flip || changed;
          end
        end
        default: ;
      endcase
    end
  end

  // Weight matrix: cleared on reset or IDLE clear; one Hebbian row per LEARN cycle, diagonal untouched.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst || clr_acc) begin
          w[i][j] <= '0;
        end else if ((state == S_LEARN) && (IDX_BITS'(i) == row) && (i != j)) begin
          w[i][j] <= W_BITS'(sat_add(int'(w[i][j]), (pat_r[i] == pat_r[j]) ? 1 : -1, WMAX));
        end
      end
    end
  end

  assign state_out = s;
  assign converged = conv_r;
  assign timeout   = tmo_r;
  assign rd_data   = w[rd_row][rd_col];

endmodule
